// File: rtl/fft8_frame_loader.sv
// rtl/fft8_frame_loader.sv - ping-pong 8-sample frame collector feeding the 8-point FFT inputs
// Optional macro FFT_IN_PRESCALE_EN: arithmetic shift right by 3 of each re/im half before storage.
module fft8_frame_loader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              sof_err
);

    localparam int HW = DATA_W / 2;

    // Two banks of eight samples; index 0 is bank A, index 1 is bank B.
    logic [DATA_W-1:0] r_mem [2][8];
    logic [1:0]        r_full;
    logic [2:0]        r_wptr;
    logic              r_fill;
    logic              r_read;
    logic              r_sof_err;

    logic              w_accept;
    logic              w_restart;
    logic              w_complete;
    logic              w_release;
    logic [2:0]        w_widx;
    logic [1:0]        w_full_nxt;
    logic [DATA_W-1:0] w_sample;

`ifdef FFT_IN_PRESCALE_EN
    logic signed [HW-1:0] w_re;
    logic signed [HW-1:0] w_im;
    assign w_re     = $signed(s_data[DATA_W-1:HW]) >>> 3;
    assign w_im     = $signed(s_data[HW-1:0]) >>> 3;
    assign w_sample = {w_re, w_im};
`else
    assign w_sample = s_data;
`endif

    assign s_ready     = !r_full[r_fill];
    assign frame_valid = r_full[r_read];
    assign sof_err     = r_sof_err;

    assign w_accept   = s_valid && s_ready;
    // An SOF in the middle of a frame throws away the partial frame and restarts at slot 0.
    assign w_restart  = w_accept && s_sof && (r_wptr != 3'd0);
    assign w_widx     = w_restart ? 3'd0 : r_wptr;
    assign w_complete = w_accept && !w_restart && (r_wptr == 3'd7);
    assign w_release  = frame_valid && frame_ready;

    // Release is applied before completion so a bank freed this edge can be refilled at once.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_read] = 1'b0;
        end
        if (w_complete) begin
            w_full_nxt[r_fill] = 1'b1;
        end
    end

    // Sample storage: accepted sample goes to the fill bank at the current (or restarted) slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    r_mem[b][i] <= '0;
                end
            end
        end else if (w_accept) begin
            r_mem[r_fill][w_widx] <= w_sample;
        end
    end

    // Fill pointer, bank selects, full flags and the sticky SOF error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= 3'd0;
            r_fill    <= 1'b0;
            r_read    <= 1'b0;
            r_full    <= 2'b00;
            r_sof_err <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wptr <= w_restart ? 3'd1 : r_wptr + 3'd1;
            end
            if (w_complete) begin
                r_fill <= !r_fill;
            end
            if (w_release) begin
                r_read <= !r_read;
            end
            if (w_restart) begin
                r_sof_err <= 1'b1;
            end
        end
    end

    assign x0 = r_mem[r_read][0];
    assign x1 = r_mem[r_read][1];
    assign x2 = r_mem[r_read][2];
    assign x3 = r_mem[r_read][3];
    assign x4 = r_mem[r_read][4];
    assign x5 = r_mem[r_read][5];
    assign x6 = r_mem[r_read][6];
    assign x7 = r_mem[r_read][7];

endmodule
